// File: rtl/vector_writeback_unit.sv
// Vector writeback: merges VFU results under vl/vm/mask and streams them to the VRF.
// Define WB_TAIL_AGNOSTIC_EN to write tail elements and tail mask bits as all-ones.
`ifndef VEC_ALU_NOP
`define VEC_ALU_NOP 2'b00
`endif
`ifndef VEC_ALU_WORKING
`define VEC_ALU_WORKING 2'b01
`endif
`ifndef VEC_ALU_FINISHED
`define VEC_ALU_FINISHED 2'b10
`endif
`ifndef ONE_BYTE
`define ONE_BYTE 3'b000
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'b001
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'b010
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'b011
`endif

module vector_writeback_unit #(
  parameter int DATA_LEN = 32,
  parameter int VECTOR_SIZE = 8,
  parameter int BEAT_WIDTH = 64,
  parameter int BEAT_INDEX_SIZE = 2,
  parameter int VREG_INDEX_SIZE = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy_in,
  input  logic [1:0] vfu_status,
  input  logic is_mask,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] result,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] old_vd,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] mask,
  input  logic vm,
  input  logic [DATA_LEN-1:0] vl,
  input  logic [2:0] vsew,
  input  logic [VREG_INDEX_SIZE-1:0] vd_index,
  output logic vrf_we,
  output logic [VREG_INDEX_SIZE+BEAT_INDEX_SIZE-1:0] vrf_addr,
  output logic [BEAT_WIDTH-1:0] vrf_wdata,
  output logic wb_busy,
  output logic wb_done,
  output logic overflow
);
  localparam int VLEN = VECTOR_SIZE * DATA_LEN;
  localparam int IW = $clog2(VLEN);
  localparam logic [BEAT_INDEX_SIZE-1:0] LAST_BEAT =
    BEAT_INDEX_SIZE'(VLEN / BEAT_WIDTH - 1);
`ifdef WB_TAIL_AGNOSTIC_EN
  localparam logic TAIL_ONES = 1'b1;
`else
  localparam logic TAIL_ONES = 1'b0;
`endif

  typedef struct packed {
    logic is_mask;
    logic [VLEN-1:0] result;
    logic [VLEN-1:0] old_vd;
    logic [VLEN-1:0] mask;
    logic vm;
    logic [DATA_LEN-1:0] vl;
    logic [2:0] vsew;
    logic [VREG_INDEX_SIZE-1:0] vd;
  } snap_t;

  typedef enum logic [1:0] {IDLE, MERGE, WRITE, DONE} state_t;

  state_t state;
  snap_t snap, act, pend;
  logic pend_valid, we_q, done_q;
  logic [BEAT_INDEX_SIZE-1:0] beat;
  logic [VLEN-1:0] merged, merge_c;
  logic [1:0] sh;
  logic [IW-1:0] bi, eidx;
  logic cap, direct, promote;

  assign snap = {is_mask, result, old_vd, mask, vm, vl, vsew, vd_index};
  assign cap = vfu_status == `VEC_ALU_FINISHED;
  assign direct = cap && rdy_in && state == IDLE && !pend_valid;
  // The pending slot drains whenever the FSM could start a new result.
  assign promote = rdy_in && pend_valid && (state == IDLE || state == DONE);

  assign vrf_we = we_q && rdy_in;
  assign wb_done = done_q && rdy_in;
  assign wb_busy = state != IDLE || pend_valid;

  always_comb begin
    case (act.vsew)
      `ONE_BYTE:   sh = 2'd0;
      `TWO_BYTE:   sh = 2'd1;
      `FOUR_BYTE:  sh = 2'd2;
      `EIGHT_BYTE: sh = 2'd3;
      default:     sh = 2'd0;
    endcase
  end

  always_comb begin
    merge_c = act.old_vd;
    bi = '0;
    eidx = '0;
    if (act.is_mask) begin
      for (int i = 0; i < VLEN; i++) begin
        bi = IW'(i);
        if (DATA_LEN'(bi) < act.vl) begin
          if (act.vm || act.mask[bi]) merge_c[bi] = act.result[bi];
        end else if (TAIL_ONES) begin
          merge_c[bi] = 1'b1;
        end
      end
    end else begin
      // Byte granularity: every SEW is a whole number of bytes.
      for (int b = 0; b < VLEN / 8; b++) begin
        bi = IW'(b * 8);
        eidx = IW'(b) >> sh;
        if (DATA_LEN'(eidx) < act.vl) begin
          if (act.vm || act.mask[eidx])
            merge_c[bi +: 8] = act.result[bi +: 8];
        end else if (TAIL_ONES) begin
          merge_c[bi +: 8] = '1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend_valid <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      beat <= '0;
      vrf_addr <= '0;
      vrf_wdata <= '0;
      overflow <= 1'b0;
    end else begin
      if (direct) act <= snap;
      else if (promote) act <= pend;
      if (cap && !direct) begin
        if (pend_valid && !promote) begin
          overflow <= 1'b1;
        end else begin
          pend <= snap;
          pend_valid <= 1'b1;
        end
      end else if (promote) begin
        pend_valid <= 1'b0;
      end
      if (rdy_in) begin
        we_q <= 1'b0;
        done_q <= 1'b0;
        unique case (state)
          IDLE: if (direct || promote) state <= MERGE;
          MERGE: begin
            merged <= merge_c;
            beat <= '0;
            state <= WRITE;
          end
          WRITE: begin
            we_q <= 1'b1;
            vrf_addr <= {act.vd, beat};
            vrf_wdata <= merged[int'(beat) * BEAT_WIDTH +: BEAT_WIDTH];
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) state <= DONE;
          end
          DONE: begin
            done_q <= 1'b1;
            state <= promote ? MERGE : IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vector_writeback_unit.sv
// Scoreboard bench for vector_writeback_unit: beats and done pulses
// are queued at issue time and matched as the DUT produces them.
module tb_vector_writeback_unit;
  localparam int VLEN = 256;
`ifdef WB_TAIL_AGNOSTIC_EN
  localparam bit TA = 1'b1;
`else
  localparam bit TA = 1'b0;
`endif

  typedef struct {
    logic [6:0] addr;
    logic [63:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst, rdy_in, is_mask, vm;
  logic [1:0] vfu_status;
  logic [VLEN-1:0] result, old_vd, mask;
  logic [31:0] vl;
  logic [2:0] vsew;
  logic [4:0] vd_index;
  logic vrf_we, wb_busy, wb_done, overflow;
  logic [6:0] vrf_addr;
  logic [63:0] vrf_wdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  beat_t exp_q[$];
  int exp_done_q[$];

  vector_writeback_unit dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .vfu_status(vfu_status),
    .is_mask(is_mask), .result(result), .old_vd(old_vd), .mask(mask),
    .vm(vm), .vl(vl), .vsew(vsew), .vd_index(vd_index),
    .vrf_we(vrf_we), .vrf_addr(vrf_addr), .vrf_wdata(vrf_wdata),
    .wb_busy(wb_busy), .wb_done(wb_done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VLEN-1:0] rnd256();
    logic [VLEN-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference merge, walked bit by bit.
  function automatic logic [VLEN-1:0] model(
    input logic im, input logic [VLEN-1:0] res, od, mk,
    input logic vmi, input logic [31:0] vli, input logic [2:0] sew);
    logic [VLEN-1:0] r;
    logic [7:0] e8;
    int w, e;
    w = (sew < 3'd4) ? (8 << sew) : 8;
    r = od;
    for (int b = 0; b < VLEN; b++) begin
      e = im ? b : b / w;
      e8 = 8'(e);
      if (32'(e) < vli) begin
        if (vmi || mk[e8]) r[8'(b)] = res[8'(b)];
      end else if (TA) begin
        r[8'(b)] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic issue(
    input logic im, input logic [VLEN-1:0] res, od, mk,
    input logic vmi, input logic [31:0] vli, input logic [2:0] sew,
    input logic [4:0] vd, input int npush, output int t);
    logic [VLEN-1:0] m;
    m = model(im, res, od, mk, vmi, vli, sew);
    for (int k = 0; k < npush; k++)
      exp_q.push_back('{addr: {vd, 2'(k)}, data: m[k*64 +: 64]});
    is_mask = im; result = res; old_vd = od; mask = mk;
    vm = vmi; vl = vli; vsew = sew; vd_index = vd;
    vfu_status = 2'b10;
    @(posedge clk);
    #1;
    t = cyc;
    vfu_status = 2'b00;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!wb_busy && exp_q.size() == 0 && exp_done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    beat_t mb;
    int dc;
    forever begin
      @(negedge clk);
      if (vrf_we) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected: addr=%0h data=%h, required no write",
                   vrf_addr, vrf_wdata);
        end else begin
          mb = exp_q.pop_front();
          if (vrf_addr !== mb.addr || vrf_wdata !== mb.data) begin
            fails++;
            $display("FAIL beat: addr=%0h data=%h, required addr=%0h data=%h",
                     vrf_addr, vrf_wdata, mb.addr, mb.data);
          end
        end
      end
      if (wb_done) begin
        tests++;
        if (exp_done_q.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: cycle=%0d, required none", cyc);
        end else begin
          dc = exp_done_q.pop_front();
          if (cyc !== dc) begin
            fails++;
            $display("FAIL done_cycle: got %0d, required %0d", cyc, dc);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy_in = 1'b1; vfu_status = 2'b00;
    is_mask = 1'b0; result = '0; old_vd = '0; mask = '0;
    vm = 1'b1; vl = '0; vsew = '0; vd_index = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({vrf_we, vrf_addr, vrf_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_vrf: we=%b addr=%0h data=%h, required 0",
               vrf_we, vrf_addr, vrf_wdata);
    end
    tests++;
    if ({wb_busy, wb_done, overflow} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: busy/done/ovf=%b, required 000",
               {wb_busy, wb_done, overflow});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (wb_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b, required 0", wb_busy);
    end
  endtask

  task automatic test_elem_four_byte();
    logic [VLEN-1:0] r;
    logic [63:0] eb[4];
    int t;
    bit ok;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'h100 + i;
`ifdef WB_TAIL_AGNOSTIC_EN
    eb = '{64'h00000101_00000100, 64'h00000103_00000102,
           64'hFFFFFFFF_00000104, 64'hFFFFFFFF_FFFFFFFF};
`else
    eb = '{64'h00000101_00000100, 64'h00000103_00000102,
           64'hAAAAAAAA_00000104, 64'hAAAAAAAA_AAAAAAAA};
`endif
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{addr: {5'd5, 2'(k)}, data: eb[k]});
    issue(1'b0, r, {8{32'hAAAAAAAA}}, '0, 1'b1, 32'd5, 3'b010, 5'd5, 0, t);
    exp_done_q.push_back(t + 6);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (vrf_we !== 1'b0 || wb_busy !== 1'b1) begin
      fails++;
      $display("FAIL merge_cycle: we=%b busy=%b, required we=0 busy=1",
               vrf_we, wb_busy);
    end
    @(negedge clk);
    tests++;
    if (vrf_we !== 1'b1 || vrf_addr !== 7'h14) begin
      fails++;
      $display("FAIL first_beat_time: we=%b addr=%0h, required we=1 addr=14",
               vrf_we, vrf_addr);
    end
    wait_idle(ok);
    tests++;
    if (!ok || overflow !== 1'b0) begin
      fails++;
      $display("FAIL four_byte_drain: ok=%b ovf=%b, required 1 0", ok, overflow);
    end
  endtask

  task automatic test_elem_masked_byte();
    logic [63:0] rest;
    int t;
    bit ok;
    rest = TA ? '1 : '0;
    exp_q.push_back('{addr: {5'd3, 2'd0}, data: 64'h0011001100110011});
    for (int k = 1; k < 4; k++)
      exp_q.push_back('{addr: {5'd3, 2'(k)}, data: rest});
    issue(1'b0, {32{8'h11}}, '0, 256'h55, 1'b0, 32'd8, 3'b000, 5'd3, 0, t);
    exp_done_q.push_back(t + 6);
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL masked_byte_drain: ok=%b, required 1", ok);
    end
  endtask

  task automatic test_mask_mode();
    logic [63:0] b0, rest;
    int t;
    bit ok;
    b0 = TA ? '1 : 64'h3FF;
    rest = TA ? '1 : '0;
    exp_q.push_back('{addr: {5'd9, 2'd0}, data: b0});
    for (int k = 1; k < 4; k++)
      exp_q.push_back('{addr: {5'd9, 2'(k)}, data: rest});
    issue(1'b1, '1, '0, '0, 1'b1, 32'd10, 3'b000, 5'd9, 0, t);
    exp_done_q.push_back(t + 6);
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL mask_mode_drain: ok=%b, required 1", ok);
    end
  endtask

  task automatic test_random_merge();
    logic [31:0] vlv;
    logic [2:0] sw;
    int t;
    bit ok;
    for (int n = 0; n < 8; n++) begin
      vlv = 32'($urandom_range(0, 70));
      sw = 3'($urandom_range(0, 7));
      if (n == 0) vlv = 32'd0;
      if (n == 1) begin
        vlv = '1;
        sw = 3'd5;
      end
      issue(1'($urandom_range(0, 1)), rnd256(), rnd256(), rnd256(),
            1'($urandom_range(0, 1)), vlv, sw, 5'($urandom_range(0, 31)), 4, t);
      exp_done_q.push_back(t + 6);
      wait_idle(ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL random_drain: iter=%0d ok=%b, required 1", n, ok);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ta, tb, tc;
    bit ok;
    issue(1'b0, rnd256(), rnd256(), rnd256(), 1'b1, 32'd40, 3'b001, 5'd1, 4, ta);
    exp_done_q.push_back(ta + 6);
    exp_done_q.push_back(ta + 12);
    @(posedge clk);
    #1;
    issue(1'b0, rnd256(), rnd256(), rnd256(), 1'b0, 32'd20, 3'b010, 5'd2, 4, tb);
    @(posedge clk);
    #1;
    issue(1'b1, rnd256(), rnd256(), rnd256(), 1'b1, 32'd99, 3'b000, 5'd4, 0, tc);
    tests++;
    if (overflow !== 1'b1 || tc !== ta + 4) begin
      fails++;
      $display("FAIL overflow_set: ovf=%b dt=%0d, required 1 4", overflow, tc - ta);
    end
    wait_idle(ok);
    tests++;
    if (!ok || overflow !== 1'b1) begin
      fails++;
      $display("FAIL b2b_drain: ok=%b ovf=%b, required 1 1", ok, overflow);
    end
  endtask

  task automatic test_stall();
    int t;
    bit ok;
    issue(1'b0, rnd256(), rnd256(), rnd256(), 1'b1, 32'd3, 3'b011, 5'd7, 4, t);
    exp_done_q.push_back(t + 9);
    repeat (3) @(posedge clk);
    #1;
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (vrf_we !== 1'b0 || vrf_addr !== {5'd7, 2'd1}) begin
        fails++;
        $display("FAIL stall_hold: we=%b addr=%0h, required we=0 addr=%0h",
                 vrf_we, vrf_addr, {5'd7, 2'd1});
      end
    end
    @(posedge clk);
    #1;
    rdy_in = 1'b1;
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL stall_drain: ok=%b, required 1", ok);
    end
  endtask

  task automatic test_reset_mid_write();
    int t;
    bit ok;
    issue(1'b0, rnd256(), rnd256(), rnd256(), 1'b1, 32'd8, 3'b010, 5'd6, 3, t);
    issue(1'b0, rnd256(), rnd256(), rnd256(), 1'b1, 32'd8, 3'b010, 5'd8, 0, t);
    issue(1'b0, rnd256(), rnd256(), rnd256(), 1'b1, 32'd8, 3'b010, 5'd9, 0, t);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_ovf: ovf=%b, required 1", overflow);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({vrf_we, wb_busy, overflow, wb_done} !== 4'b0000) begin
      fails++;
      $display("FAIL mid_reset: we/busy/ovf/done=%b, required 0000",
               {vrf_we, wb_busy, overflow, wb_done});
    end
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    wait_idle(ok);
    tests++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL mid_reset_drain: ok=%b left=%0d, required 1 0",
               ok, exp_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_elem_four_byte();
    test_elem_masked_byte();
    test_mask_mode();
    test_random_merge();
    test_back_to_back();
    test_stall();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
